// File: rtl/clken_pkg.sv
// Shared constants and types for the fractional clock-enable generator.
// Defaults for ratio width, lock-synchroniser depth and core reset hold.
package clken_pkg;

  localparam int W_DEFAULT           = 8;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int RST_HOLD_DEFAULT    = 16;
  localparam int HOLD_W              = 16;

  typedef logic [W_DEFAULT-1:0] ratio_t;

endpackage

// File: rtl/clken_chan.sv
// One fractional clock-enable channel: ce rate = f_clk * num_s / den_s.
// Ports: i_clk, i_rst, i_run (core out of reset), i_en, i_num, i_den, o_ce, o_ph.
module clken_chan
  import clken_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_run,
  input  logic         i_en,
  input  logic [W-1:0] i_num,
  input  logic [W-1:0] i_den,
  output logic         o_ce,
  output logic         o_ph
);

  logic [W-1:0] r_num_s;
  logic [W-1:0] r_den_s;
  logic [W-1:0] r_acc;
  logic         r_en_d;
  logic         r_run_d;

  logic         w_load;
  logic         w_act;
  logic         w_clamp;
  logic         w_hit;
  logic [W:0]   w_sum;
  logic [W:0]   w_den_x;

  // Capture ratio on en rising, or when the core leaves reset with en set.
  assign w_load  = i_en & (~r_en_d | (i_run & ~r_run_d));
  // The load cycle itself does no step, so stepping starts with fresh ratio.
  assign w_act   = i_run & i_en & (r_den_s != '0) & ~w_load;
  assign w_sum   = {1'b0, r_acc} + {1'b0, r_num_s};
  assign w_den_x = {1'b0, r_den_s};
  assign w_clamp = r_num_s >= r_den_s;
  assign w_hit   = w_sum >= w_den_x;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_num_s <= '0;
      r_den_s <= '0;
      r_acc   <= '0;
      r_en_d  <= 1'b0;
      r_run_d <= 1'b0;
      o_ce    <= 1'b0;
      o_ph    <= 1'b0;
    end else begin
      r_en_d  <= i_en;
      r_run_d <= i_run;
      if (w_load) begin
        r_num_s <= i_num;
        r_den_s <= i_den;
      end
      if (!w_act) begin
        r_acc <= '0;
        o_ce  <= 1'b0;
        o_ph  <= 1'b0;
      end else if (w_clamp) begin
        r_acc <= '0;
        o_ce  <= 1'b1;
        o_ph  <= ~o_ph;
      end else if (w_hit) begin
        r_acc <= W'(w_sum - w_den_x);
        o_ce  <= 1'b1;
        o_ph  <= ~o_ph;
      end else begin
        r_acc <= w_sum[W-1:0];
        o_ce  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clken_gen.sv
// Lock synchroniser, core reset sequencer and NCH fractional enable channels.
// Ports: inclk0, areset, locked_in, en/num/den (per channel), ce, ph, rst_out, ready.
module clken_gen
  import clken_pkg::*;
#(
  parameter int NCH         = 3,
  parameter int W           = W_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int RST_HOLD    = RST_HOLD_DEFAULT
) (
  input  logic             inclk0,
  input  logic             areset,
  input  logic             locked_in,
  input  logic [NCH-1:0]   en,
  input  logic [NCH*W-1:0] num,
  input  logic [NCH*W-1:0] den,
  output logic [NCH-1:0]   ce,
  output logic [NCH-1:0]   ph,
  output logic             rst_out,
  output logic             ready
);

  localparam logic [HOLD_W-1:0] HOLD = HOLD_W'(RST_HOLD);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [HOLD_W-1:0]      r_hold;
  logic                   w_lk_s;
  logic                   w_rst_nxt;
  logic                   w_run;

  assign w_lk_s    = r_sync[SYNC_STAGES-1];
  // Lock loss forces reset at once, without waiting for the cleared counter.
  assign w_rst_nxt = ~w_lk_s | (r_hold < HOLD);
  assign w_run     = ~rst_out;

  always_ff @(posedge inclk0 or posedge areset) begin
    if (areset) begin
      r_sync  <= '0;
      r_hold  <= '0;
      rst_out <= 1'b1;
      ready   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], locked_in};
      if (!w_lk_s)
        r_hold <= '0;
      else if (r_hold < HOLD)
        r_hold <= r_hold + 1'b1;
      rst_out <= w_rst_nxt;
      ready   <= ~w_rst_nxt;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clken_chan #(
      .W(W)
    ) u_chan (
      .i_clk (inclk0),
      .i_rst (areset),
      .i_run (w_run),
      .i_en  (en[i]),
      .i_num (num[i*W +: W]),
      .i_den (den[i*W +: W]),
      .o_ce  (ce[i]),
      .o_ph  (ph[i])
    );
  end

endmodule

// File: tb/tb_clken_gen.sv
// Directed bench for clken_gen: lock sequence, ratios, runtime changes, resets.
// Expected values are hand-derived from the enable-rate behaviour.
module tb_clken_gen;

  logic        clk = 1'b0;
  logic        areset;
  logic        locked_in;
  logic [2:0]  en;
  logic [23:0] num;
  logic [23:0] den;
  logic [2:0]  ce;
  logic [2:0]  ph;
  logic        rst_out;
  logic        ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clken_gen #(
    .NCH(3),
    .W(8),
    .SYNC_STAGES(2),
    .RST_HOLD(16)
  ) dut (
    .inclk0    (clk),
    .areset    (areset),
    .locked_in (locked_in),
    .en        (en),
    .num       (num),
    .den       (den),
    .ce        (ce),
    .ph        (ph),
    .rst_out   (rst_out),
    .ready     (ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] pat;
    logic [2:0] ce_m;
    logic [2:0] ph_m;
    logic [3:0] acc_or;
    int c0, c1, c2, cnt;

    areset    = 1'b1;
    locked_in = 1'b0;
    en        = '0;
    num       = '0;
    den       = '0;
    tick;
    tick;
    chk("rst_ce", ce, 0);
    chk("rst_ph", ph, 0);
    chk("rst_rst_out", rst_out, 1);
    chk("rst_ready", ready, 0);

    num = {8'd5, 8'd3, 8'd1};
    den = {8'd5, 8'd8, 8'd12};
    en  = 3'b111;
    tick;
    areset = 1'b0;
    tick;
    tick;
    chk("nolock_rst", rst_out, 1);

    locked_in = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick;
      chk("lock_seq", {ready, rst_out}, (k < 19) ? 2'b01 : 2'b10);
    end

    tick;
    chk("load_edge_ce", ce, 0);

    pat  = 8'b1010_0100;
    ph_m = '0;
    for (int j = 1; j <= 24; j++) begin
      tick;
      ce_m = {1'b1, pat[(j-1)%8], (j % 12 == 0)};
      ph_m = ph_m ^ ce_m;
      chk("ratio_ce", ce, ce_m);
      chk("ratio_ph", ph, ph_m);
    end

    c0 = 0; c1 = 0; c2 = 0;
    for (int j = 0; j < 800; j++) begin
      tick;
      c0 += int'(ce[0]);
      c1 += int'(ce[1]);
      c2 += int'(ce[2]);
    end
    chk("cnt_1_12", c0, 66);
    chk("cnt_3_8", c1, 300);
    chk("cnt_5_5", c2, 800);

    num[7:0] = 8'd1;
    den[7:0] = 8'd2;
    c0 = 0;
    for (int j = 0; j < 12; j++) begin
      tick;
      c0 += int'(ce[0]);
    end
    chk("runtime_ignored", c0, 1);

    en[0] = 1'b0;
    tick;
    chk("en_off_ce0", ce[0], 0);
    chk("en_off_ph0", ph[0], 0);
    en[0] = 1'b1;
    tick;
    chk("reload_edge_ce0", ce[0], 0);
    for (int j = 1; j <= 4; j++) begin
      tick;
      chk("new_ratio_1_2", ce[0], (j % 2 == 0));
    end

    en[2:1] = 2'b00;
    tick;
    num[23:8] = {8'd4, 8'd0};
    den[23:8] = {8'd0, 8'd7};
    en[2:1]   = 2'b11;
    tick;
    acc_or = '0;
    for (int j = 0; j < 20; j++) begin
      tick;
      acc_or = acc_or | {ce[2:1], ph[2:1]};
    end
    chk("num0_den0_quiet", acc_or, 0);

    locked_in = 1'b0;
    tick;
    tick;
    tick;
    chk("lockloss_rst", rst_out, 1);
    chk("lockloss_ready", ready, 0);
    tick;
    chk("lockloss_ce", ce, 0);
    chk("lockloss_ph", ph, 0);

    locked_in = 1'b1;
    cnt = 0;
    while (rst_out && cnt < 40) begin
      tick;
      cnt++;
    end
    chk("relock_edges", cnt, 19);
    tick;
    chk("relock_load_ce", ce, 0);
    tick;
    chk("relock_step1", ce, 0);
    tick;
    chk("relock_step2", ce, 3'b001);
    chk("relock_ph", ph, 3'b001);

    #1;
    areset = 1'b1;
    #1;
    chk("areset_ce", ce, 0);
    chk("areset_ph", ph, 0);
    chk("areset_rst", rst_out, 1);
    chk("areset_ready", ready, 0);
    tick;
    areset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clken_gen.md
Name: clken_gen

Overview:
- Parametrised successor to the board PLL wrapper. It runs on one PLL output clock and derives NCH fractional-rate clock-enable channels from it, each with a 50%-duty phase output, instead of extra MMCM outputs or ad-hoc counter dividers.
- It also synchronises the MMCM lock signal and sequences a synchronous core reset.
- It sits directly after the PLL wrapper. Its enables drive core logic (CPU, video, sound) on the same clock.

Parameters:
- NCH, 3: number of enable channels (1-8).
- W, 8: width of the per-channel NUM/DEN ratio fields.
- SYNC_STAGES, 2: flip-flop depth of the lock synchroniser (≥2).
- RST_HOLD, 16: cycles the core reset stays asserted after lock is seen (1-65535).

Ports:
- inclk0, in, 1: master clock (PLL output, e.g. 72 MHz).
- areset, in, 1: asynchronous active-high reset.
- locked_in, in, 1: MMCM LOCKED. Asynchronous to inclk0.
- en, in, NCH: per-channel run enable (level).
- num, in, NCH*W: per-channel numerator. Channel i is bits [i*W +: W].
- den, in, NCH*W: per-channel denominator, same packing.
- ce, out, NCH: per-channel one-cycle enable pulse, registered.
- ph, out, NCH: per-channel phase; toggles on each ce pulse.
- rst_out, out, 1: synchronous active-high core reset.
- ready, out, 1: equals ~rst_out, registered.

Behaviour:
- Interface: one clock, inclk0; reset is asynchronous and active-high on areset. All flops clear asynchronously on areset.
- Reset values: ce=0, ph=0, rst_out=1, ready=0, accumulators=0, shadow NUM/DEN=0, hold counter=0, synchroniser=0.
- Lock synchroniser: locked_in passes through SYNC_STAGES flops to give lk_s.
- Hold counter (16 bit):
  - lk_s=0: cleared.
  - lk_s=1 and counter<RST_HOLD: increments; saturates at RST_HOLD.
  - rst_out = (counter<RST_HOLD), registered.
- Latency: first clock edge with locked_in=1 → rst_out falls after exactly SYNC_STAGES+RST_HOLD+1 edges.
- Lock loss: lk_s falling → rst_out=1 on the next edge. All channels then stop and clear (see "Stopped").
- Channel is active when rst_out=0 and en[i]=1 and shadow den_s≠0.
- Shadow load: num_s/den_s load from num/den on the cycle en[i] rises, or on the cycle rst_out falls while en[i]=1. Changes to num/den while a channel runs are ignored until the next load.
- Active-cycle step:
  - sum = acc + num_s, computed in W+1 bits.
  - If num_s ≥ den_s: clamp. ce=1 every cycle, acc=0.
  - Else if sum ≥ den_s: acc ← sum − den_s, ce ← 1.
  - Else: acc ← sum, ce ← 0.
- Average rate: f_ce = f_clk × num_s / den_s. No drift; the pattern is exactly periodic over den_s cycles.
- ph[i] toggles on every cycle ce[i] is asserted, so f_ph = f_ce / 2.
- Stopped (inactive, including rst_out=1): ce=0 on the next edge, acc=0, ph=0.
- num_s=0 with den_s≠0: active but never pulses; ph holds 0.
- den=0 at load: channel stays inactive.
- Simultaneous rst_out fall and en rise: shadow loads once; the first step happens on the following cycle.
- First ce of a channel occurs ceil(den_s/num_s) active cycles after activation. For num_s=1 that is den_s cycles.
- areset mid-operation: everything returns to reset values immediately; the lock sequence restarts.

Decomposition:
- Package clken_pkg:
  - W_DEFAULT, SYNC_STAGES_DEFAULT, RST_HOLD_DEFAULT constants.
  - Typedef of the packed channel ratio field.
- Sub-module clken_chan: one fractional channel (shadow regs, accumulator, ce, ph). Instantiated NCH times in a generate loop.
- Top level holds the synchroniser and the hold counter.

Test Plan:
- Lock sequence: SYNC_STAGES=2, RST_HOLD=16, areset pulse, then locked_in=1 → rst_out=1 for exactly 19 edges, then 0; ready mirrors.
- Integer divide: NUM=1, DEN=12 at 72 MHz → ce every 12th cycle (6 MHz); ph period 24 cycles. NUM=1, DEN=2 → ce on alternate cycles.
- Fractional: NUM=3, DEN=8 → exactly 3 pulses per 8 cycles, repeating pattern 0,0,1,0,0,1,0,1 from activation; 300 pulses in 800 cycles.
- Edge ratios:
  - NUM=5, DEN=5 → ce constant 1.
  - NUM=0, DEN=7 → ce never asserts.
  - DEN=0 → channel inactive; ph stays 0.
- Runtime change: change num/den while en=1 → rate unchanged. Toggle en 0→1 → new ratio applies; acc restarts at 0.
- Lock loss and reset:
  - Drop locked_in mid-run → rst_out=1 within SYNC_STAGES+1 edges; all ce=0, ph=0.
  - Restore lock → channels restart after the full hold.
  - areset mid-pulse → all outputs at reset values immediately.
